// File: rtl/reg_access_arbiter.sv
// Two-requester round-robin sequencer for the 2-entry register file; captures OUT data back to the owner.
// Optional lock support (req0_lock/req1_lock, atomic sequences) is compiled in with `define ARB_LOCK_EN.
module reg_access_arbiter #(
    parameter int unsigned CAPTURE_DELAY = 1
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_ena,
    input  logic       i_req0_valid,
    output logic       o_req0_ready,
    input  logic [2:0] i_req0_opcode,
    input  logic [7:0] i_req0_data,
    input  logic       i_req1_valid,
    output logic       o_req1_ready,
    input  logic [2:0] i_req1_opcode,
    input  logic [7:0] i_req1_data,
`ifdef ARB_LOCK_EN
    input  logic       i_req0_lock,
    input  logic       i_req1_lock,
`endif
    output logic       o_rsp0_valid,
    output logic       o_rsp1_valid,
    output logic [7:0] o_rsp_data,
    output logic       o_reg_ena,
    output logic [2:0] o_reg_opcode,
    output logic [7:0] o_reg_data,
    input  logic [7:0] i_reg_data_out,
    output logic       o_busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT    = 2'd2,
        S_CAPTURE = 2'd3
    } state_t;

    // WAIT spends CAPTURE_DELAY-1 cycles; the counter holds the remaining count minus one.
    localparam logic [2:0] WAIT_INIT = 3'((CAPTURE_DELAY >= 2) ? (CAPTURE_DELAY - 2) : 0);

    state_t     r_state;
    logic       r_rr_ptr;
    logic       r_owner;
    logic [2:0] r_op;
    logic [7:0] r_data;
    logic [2:0] r_wait_cnt;
    logic       r_rsp0;
    logic       r_rsp1;
    logic [7:0] r_rsp_data;
    logic       r_reg_ena;
`ifdef ARB_LOCK_EN
    logic       r_lat_lock;
    logic       r_lock_act;
    logic       r_lock_owner;
    logic       w_sel_lock;
`endif

    logic       w_elig0;
    logic       w_elig1;
    logic       w_win0;
    logic       w_win1;
    logic       w_can_accept;
    logic       w_hs0;
    logic       w_hs1;
    logic       w_hs;
    logic [2:0] w_sel_op;
    logic [7:0] w_sel_data;
    logic       w_is_out;

`ifdef ARB_LOCK_EN
    // While a lock is held only its owner is eligible, even if it is idle.
    assign w_elig0    = i_req0_valid & (~r_lock_act | ~r_lock_owner);
    assign w_elig1    = i_req1_valid & (~r_lock_act |  r_lock_owner);
    assign w_sel_lock = w_hs1 ? i_req1_lock : i_req0_lock;
`else
    assign w_elig0 = i_req0_valid;
    assign w_elig1 = i_req1_valid;
`endif

    assign w_win1       = w_elig1 & (~w_elig0 | r_rr_ptr);
    assign w_win0       = w_elig0 & ~w_win1;
    assign w_can_accept = i_ena & ~i_reset & (r_state == S_IDLE);
    assign o_req0_ready = w_can_accept & w_win0;
    assign o_req1_ready = w_can_accept & w_win1;
    assign w_hs0        = o_req0_ready & i_req0_valid;
    assign w_hs1        = o_req1_ready & i_req1_valid;
    assign w_hs         = w_hs0 | w_hs1;
    assign w_sel_op     = w_hs1 ? i_req1_opcode : i_req0_opcode;
    assign w_sel_data   = w_hs1 ? i_req1_data   : i_req0_data;
    assign w_is_out     = (r_op[2:1] == 2'b10);

    // Pulses are held in their registers while frozen so they reappear once ena returns.
    assign o_reg_ena    = r_reg_ena & i_ena;
    assign o_rsp0_valid = r_rsp0 & i_ena;
    assign o_rsp1_valid = r_rsp1 & i_ena;
    assign o_rsp_data   = r_rsp_data;
    assign o_reg_opcode = r_op;
    assign o_reg_data   = r_data;
    assign o_busy       = (r_state != S_IDLE);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_rr_ptr   <= 1'b0;
            r_owner    <= 1'b0;
            r_op       <= 3'd0;
            r_data     <= 8'd0;
            r_wait_cnt <= 3'd0;
            r_rsp0     <= 1'b0;
            r_rsp1     <= 1'b0;
            r_rsp_data <= 8'd0;
            r_reg_ena  <= 1'b0;
`ifdef ARB_LOCK_EN
            r_lat_lock   <= 1'b0;
            r_lock_act   <= 1'b0;
            r_lock_owner <= 1'b0;
`endif
        end else if (i_ena) begin
            r_rsp0    <= 1'b0;
            r_rsp1    <= 1'b0;
            r_reg_ena <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_hs) begin
                        r_owner   <= w_hs1;
                        r_op      <= w_sel_op;
                        r_data    <= w_sel_data;
                        r_rr_ptr  <= ~w_hs1;
                        r_reg_ena <= 1'b1;
                        r_state   <= S_ISSUE;
`ifdef ARB_LOCK_EN
                        r_lat_lock <= w_sel_lock;
                        if (w_sel_lock) begin
                            r_lock_act   <= 1'b1;
                            r_lock_owner <= w_hs1;
                        end
`endif
                    end
                end
                S_ISSUE: begin
                    if (w_is_out) begin
                        r_wait_cnt <= WAIT_INIT;
                        r_state    <= (CAPTURE_DELAY <= 1) ? S_CAPTURE : S_WAIT;
                    end else begin
                        r_rsp0  <= ~r_owner;
                        r_rsp1  <=  r_owner;
                        r_state <= S_IDLE;
`ifdef ARB_LOCK_EN
                        if (r_lock_act && (r_lock_owner == r_owner) && !r_lat_lock)
                            r_lock_act <= 1'b0;
`endif
                    end
                end
                S_WAIT: begin
                    if (r_wait_cnt == 3'd0)
                        r_state <= S_CAPTURE;
                    else
                        r_wait_cnt <= r_wait_cnt - 3'd1;
                end
                S_CAPTURE: begin
                    r_rsp_data <= i_reg_data_out;
                    r_rsp0     <= ~r_owner;
                    r_rsp1     <=  r_owner;
                    r_state    <= S_IDLE;
`ifdef ARB_LOCK_EN
                    if (r_lock_act && (r_lock_owner == r_owner) && !r_lat_lock)
                        r_lock_act <= 1'b0;
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Directed bench: one arbiter with CAPTURE_DELAY=1 (dut a) and one with 3 (dut b), each on a small register-file model.
module tb_reg_access_arbiter;

    logic clk = 1'b0;
    logic rst;
    logic ena;
    always #5 clk = ~clk;

    logic       a_r0v, a_r0rdy, a_r1v, a_r1rdy, a_rsp0, a_rsp1, a_rena, a_busy;
    logic [2:0] a_r0op, a_r1op, a_rop;
    logic [7:0] a_r0d, a_r1d, a_rspd, a_rdat, a_rdo, a_rf0, a_rf1;
    logic       b_r0v, b_r0rdy, b_r1v, b_r1rdy, b_rsp0, b_rsp1, b_rena, b_busy;
    logic [2:0] b_r0op, b_r1op, b_rop;
    logic [7:0] b_r0d, b_r1d, b_rspd, b_rdat, b_rdo, b_rf0, b_rf1;
`ifdef ARB_LOCK_EN
    logic a_l0, a_l1, b_l0, b_l1;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    reg_access_arbiter #(.CAPTURE_DELAY(1)) u_dut_a (
        .i_clock(clk), .i_reset(rst), .i_ena(ena),
        .i_req0_valid(a_r0v), .o_req0_ready(a_r0rdy), .i_req0_opcode(a_r0op), .i_req0_data(a_r0d),
        .i_req1_valid(a_r1v), .o_req1_ready(a_r1rdy), .i_req1_opcode(a_r1op), .i_req1_data(a_r1d),
`ifdef ARB_LOCK_EN
        .i_req0_lock(a_l0), .i_req1_lock(a_l1),
`endif
        .o_rsp0_valid(a_rsp0), .o_rsp1_valid(a_rsp1), .o_rsp_data(a_rspd),
        .o_reg_ena(a_rena), .o_reg_opcode(a_rop), .o_reg_data(a_rdat),
        .i_reg_data_out(a_rdo), .o_busy(a_busy)
    );

    reg_access_arbiter #(.CAPTURE_DELAY(3)) u_dut_b (
        .i_clock(clk), .i_reset(rst), .i_ena(ena),
        .i_req0_valid(b_r0v), .o_req0_ready(b_r0rdy), .i_req0_opcode(b_r0op), .i_req0_data(b_r0d),
        .i_req1_valid(b_r1v), .o_req1_ready(b_r1rdy), .i_req1_opcode(b_r1op), .i_req1_data(b_r1d),
`ifdef ARB_LOCK_EN
        .i_req0_lock(b_l0), .i_req1_lock(b_l1),
`endif
        .o_rsp0_valid(b_rsp0), .o_rsp1_valid(b_rsp1), .o_rsp_data(b_rspd),
        .o_reg_ena(b_rena), .o_reg_opcode(b_rop), .o_reg_data(b_rdat),
        .i_reg_data_out(b_rdo), .o_busy(b_busy)
    );

    // Register file: 000/001 LOAD R0/R1, 010 R0<=R1, 011 R1<=R0, 100/101 OUT R0/R1, 11x clears data_out.
    always @(posedge clk) begin
        if (rst) begin
            a_rf0 <= 8'd0; a_rf1 <= 8'd0; a_rdo <= 8'd0;
        end else if (a_rena) begin
            case (a_rop)
                3'b000:  a_rf0 <= a_rdat;
                3'b001:  a_rf1 <= a_rdat;
                3'b010:  a_rf0 <= a_rf1;
                3'b011:  a_rf1 <= a_rf0;
                3'b100:  a_rdo <= a_rf0;
                3'b101:  a_rdo <= a_rf1;
                default: a_rdo <= 8'd0;
            endcase
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            b_rf0 <= 8'd0; b_rf1 <= 8'd0; b_rdo <= 8'd0;
        end else if (b_rena) begin
            case (b_rop)
                3'b000:  b_rf0 <= b_rdat;
                3'b001:  b_rf1 <= b_rdat;
                3'b010:  b_rf0 <= b_rf1;
                3'b011:  b_rf1 <= b_rf0;
                3'b100:  b_rdo <= b_rf0;
                3'b101:  b_rdo <= b_rf1;
                default: b_rdo <= 8'd0;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; ena = 1'b1;
        a_r0v = 0; a_r0op = 0; a_r0d = 0; a_r1v = 0; a_r1op = 0; a_r1d = 0;
        b_r0v = 0; b_r0op = 0; b_r0d = 0; b_r1v = 0; b_r1op = 0; b_r1d = 0;
`ifdef ARB_LOCK_EN
        a_l0 = 0; a_l1 = 0; b_l0 = 0; b_l1 = 0;
`endif
        step(); step();
        rst = 1'b0;

        // LOAD R0 0x5A then OUT R0 on dut a
        a_r0v = 1; a_r0op = 3'b000; a_r0d = 8'h5A;
        smp();
        chk("rst_reg_ena", a_rena, 0);
        chk("rst_reg_op", a_rop, 0);
        chk("rst_reg_data", a_rdat, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_rsp0", a_rsp0, 0);
        chk("rst_rsp1", a_rsp1, 0);
        chk("rst_rsp_data", a_rspd, 0);
        chk("load_ready0", a_r0rdy, 1);
        step(); a_r0v = 0;
        smp();
        chk("load_ena", a_rena, 1);
        chk("load_op", a_rop, 3'b000);
        chk("load_data", a_rdat, 8'h5A);
        chk("load_busy", a_busy, 1);
        chk("load_ready_busy", a_r0rdy, 0);
        step(); a_r0v = 1; a_r0op = 3'b100; a_r0d = 8'h00;
        smp();
        chk("load_rsp0", a_rsp0, 1);
        chk("load_rsp_data_kept", a_rspd, 0);
        chk("load_ena_one_cycle", a_rena, 0);
        chk("out_accept_t2", a_r0rdy, 1);
        step(); a_r0v = 0;
        smp();
        chk("out_ena", a_rena, 1);
        chk("out_op", a_rop, 3'b100);
        step(); smp();
        chk("out_capture_rsp0", a_rsp0, 0);
        chk("out_capture_busy", a_busy, 1);
        step(); smp();
        chk("out_rsp0", a_rsp0, 1);
        chk("out_rsp_data", a_rspd, 8'h5A);
        chk("out_idle", a_busy, 0);

        // reset during the ISSUE cycle of an OUT from req0 (rr_ptr now points at req1)
        step(); a_r0v = 1; a_r0op = 3'b100;
        smp();
        chk("solo_ready0", a_r0rdy, 1);
        step(); a_r0v = 0; rst = 1;
        smp();
        chk("mid_issue_ena", a_rena, 1);
        step(); rst = 0;
        smp();
        chk("mrst_reg_ena", a_rena, 0);
        chk("mrst_reg_op", a_rop, 0);
        chk("mrst_reg_data", a_rdat, 0);
        chk("mrst_busy", a_busy, 0);
        chk("mrst_rsp0", a_rsp0, 0);
        chk("mrst_rsp_data", a_rspd, 0);

        // both requesters valid continuously: grants alternate starting at req0 (rr_ptr reset to 0)
        step();
        a_r0v = 1; a_r0op = 3'b110; a_r0d = 8'h11;
        a_r1v = 1; a_r1op = 3'b111; a_r1d = 8'h22;
        for (int c = 0; c < 8; c++) begin
            smp();
            chk("rr_ready0", a_r0rdy, (c % 4) == 0);
            chk("rr_ready1", a_r1rdy, (c % 4) == 2);
            chk("rr_reg_ena", a_rena, (c % 2) == 1);
            chk("rr_busy", a_busy, (c % 2) == 1);
            chk("rr_rsp0", a_rsp0, (c % 4) == 2);
            chk("rr_rsp1", a_rsp1, ((c % 4) == 0) && (c > 0));
            if ((c % 2) == 1) begin
                chk("rr_reg_data", a_rdat, ((c % 4) == 1) ? 8'h11 : 8'h22);
                chk("rr_reg_op", a_rop, ((c % 4) == 1) ? 3'b110 : 3'b111);
            end
            step();
        end
        // req1 alone right after its own grant: still granted back-to-back
        a_r0v = 0;
        smp();
        chk("solo1_ready1", a_r1rdy, 1);
        chk("solo1_ready0", a_r0rdy, 0);
        chk("solo1_rsp1", a_rsp1, 1);
        step(); smp();
        chk("solo1_data", a_rdat, 8'h22);
        step(); smp();
        chk("solo1_again", a_r1rdy, 1);
        step(); a_r1v = 0;

        // CAPTURE_DELAY=3: LOAD R1 0xC3, OUT R1 -> rsp1 at T+5
        rst = 1; step(); step(); rst = 0;
        b_r1v = 1; b_r1op = 3'b001; b_r1d = 8'hC3;
        smp();
        chk("d3_ready1", b_r1rdy, 1);
        step(); b_r1v = 0;
        smp();
        chk("d3_load_ena", b_rena, 1);
        chk("d3_load_data", b_rdat, 8'hC3);
        step(); b_r1v = 1; b_r1op = 3'b101; b_r1d = 8'h00;
        smp();
        chk("d3_load_rsp1", b_rsp1, 1);
        chk("d3_out_ready1", b_r1rdy, 1);
        step(); b_r1v = 0;
        smp();
        chk("d3_out_ena", b_rena, 1);
        chk("d3_out_op", b_rop, 3'b101);
        for (int i = 2; i <= 4; i++) begin
            step(); smp();
            chk("d3_wait_rsp1", b_rsp1, 0);
            chk("d3_wait_busy", b_busy, 1);
            chk("d3_wait_ena", b_rena, 0);
        end
        step(); smp();
        chk("d3_rsp1", b_rsp1, 1);
        chk("d3_rsp_data", b_rspd, 8'hC3);
        chk("d3_idle", b_busy, 0);

        // ena low 4 cycles mid-WAIT: response arrives 4 cycles late
        step(); b_r0v = 1; b_r0op = 3'b000; b_r0d = 8'h3C;
        smp();
        chk("fz_load_ready0", b_r0rdy, 1);
        step(); b_r0v = 0;
        step(); b_r0v = 1; b_r0op = 3'b100;
        smp();
        chk("fz_out_ready0", b_r0rdy, 1);
        step(); b_r0v = 0;
        smp();
        chk("fz_issue_ena", b_rena, 1);
        step(); smp();
        chk("fz_wait_busy", b_busy, 1);
        step(); ena = 0; b_r0v = 1; b_r0op = 3'b000; b_r0d = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            smp();
            chk("fz_reg_ena", b_rena, 0);
            chk("fz_busy", b_busy, 1);
            chk("fz_rsp0", b_rsp0, 0);
            chk("fz_ready0", b_r0rdy, 0);
            step();
        end
        ena = 1; b_r0v = 0;
        smp();
        chk("fz_resume_rsp0", b_rsp0, 0);
        step(); smp();
        chk("fz_capture_rsp0", b_rsp0, 0);
        chk("fz_capture_busy", b_busy, 1);
        step(); smp();
        chk("fz_rsp0", b_rsp0, 1);
        chk("fz_rsp_data", b_rspd, 8'h3C);
        chk("fz_rsp1_excl", b_rsp1, 0);

`ifdef ARB_LOCK_EN
        // req1 locks through LOAD, MOV (lock=1), OUT (lock=0); req0 waits until the OUT response
        rst = 1; step(); step(); rst = 0;
        a_r1v = 1; a_r1op = 3'b001; a_r1d = 8'h77; a_l1 = 1;
        smp();
        chk("lk_ready1", a_r1rdy, 1);
        step();
        a_r0v = 1; a_r0op = 3'b110; a_r1op = 3'b010; a_l1 = 1;
        smp();
        chk("lk_issue_ready0", a_r0rdy, 0);
        step(); smp();
        chk("lk_mov_ready0", a_r0rdy, 0);
        chk("lk_mov_ready1", a_r1rdy, 1);
        chk("lk_load_rsp1", a_rsp1, 1);
        step(); a_r1op = 3'b101; a_l1 = 0;
        smp();
        chk("lk_issue2_ready0", a_r0rdy, 0);
        step(); smp();
        chk("lk_out_ready0", a_r0rdy, 0);
        chk("lk_out_ready1", a_r1rdy, 1);
        step(); a_r1v = 0;
        smp();
        chk("lk_out_issue_ready0", a_r0rdy, 0);
        step(); smp();
        chk("lk_capture_ready0", a_r0rdy, 0);
        step(); smp();
        chk("lk_rsp1", a_rsp1, 1);
        chk("lk_rsp_data", a_rspd, 8'h77);
        chk("lk_released_ready0", a_r0rdy, 1);
        step(); a_r0v = 0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_access_arbiter.md
Name: reg_access_arbiter

Overview:
Two-requester controller that sequences all accesses to the 2-entry register file (R0/R1; LOAD/MOV/OUT/NOP opcodes).
- Requester 0 is the decoder path; requester 1 is the UART debug host.
- Grants round-robin and drives the register file's ena/opcode/data_in for exactly one cycle per transaction.
- For OUT opcodes, captures the register file's data_out and returns it to the granted requester with a completion pulse.

Parameters:
CAPTURE_DELAY, 1, cycles from the register file's ena cycle to the cycle reg_data_out is sampled; legal 1..7.

Ports:
clock  in  1  single system clock
reset  in  1  synchronous, active-high reset
ena  in  1  global enable; low freezes FSM and all registers
req0_valid  in  1  requester 0 transaction valid
req0_ready  out  1  requester 0 accept (handshake = valid & ready)
req0_opcode  in  3  requester 0 register-file opcode
req0_data  in  8  requester 0 data (used by LOAD)
req1_valid  in  1  requester 1 transaction valid
req1_ready  out  1  requester 1 accept
req1_opcode  in  3  requester 1 opcode
req1_data  in  8  requester 1 data
rsp0_valid  out  1  one-cycle completion pulse to requester 0
rsp1_valid  out  1  one-cycle completion pulse to requester 1
rsp_data  out  8  shared response data; valid when either rspN_valid is high
reg_ena  out  1  to register file ena
reg_opcode  out  3  to register file opcode
reg_data  out  8  to register file data_in
reg_data_out  in  8  from register file data_out
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (synchronous, clock edge with reset=1):
  - state=IDLE, rr_ptr=0.
  - Latched op/data=0; rsp_data=0; rsp0_valid=rsp1_valid=0.
  - reg_ena=0, reg_opcode=0, reg_data=0, busy=0.
- Reset mid-transaction abandons the transaction: no rsp pulse, no further reg_ena.
- ena=0: state, rr_ptr and latches hold; reqN_ready=0, reg_ena=0; rsp valids forced 0 that cycle. A pending CAPTURE_DELAY count pauses and resumes.
- FSM states: IDLE, ISSUE, WAIT, CAPTURE.
- IDLE:
  - reqN_ready is combinational, asserted only for the grant winner.
  - Winner: if only one valid, that one; if both valid, requester rr_ptr.
  - On handshake at edge T: latch opcode/data and owner; rr_ptr <= ~owner; go to ISSUE.
- ISSUE (cycle T+1): reg_ena=1, reg_opcode/reg_data = latched values; registered outputs, one cycle only.
  - Opcode 100/101 (OUT): go to WAIT, or to CAPTURE if CAPTURE_DELAY=1.
  - Any other opcode: go to IDLE; rspN_valid of owner =1 in cycle T+2; rsp_data unchanged.
- WAIT: count CAPTURE_DELAY-1 cycles, then go to CAPTURE.
- CAPTURE: rsp_data <= reg_data_out; rspN_valid of owner =1 in the following cycle; go to IDLE.
- Latency with CAPTURE_DELAY=1:
  - Non-OUT: accept T, reg_ena T+1, rsp T+2, next accept possible at T+2.
  - OUT: rsp and data at T+3, next accept possible at T+3.
- reqN_ready=0 in every non-IDLE state; requester inputs are ignored while busy.
- Opcodes 110/111 are passed through unmodified (register file treats them as NOP, clears data_out); completion as non-OUT.
- rsp0_valid and rsp1_valid are never high in the same cycle.
- Single requester alone is granted back-to-back regardless of rr_ptr.

Optional Feature:
Macro: ARB_LOCK_EN.
- Defined:
  - Adds inputs req0_lock and req1_lock (1 bit each), sampled at handshake.
  - Accepted lock=1 sets lock_owner. Subsequent IDLE arbitration grants only lock_owner; the other requester's ready=0 even if lock_owner is idle.
  - Lock clears when lock_owner completes a transaction accepted with lock=0.
  - Reset clears the lock.
  - Intended for atomic LOAD/MOV/OUT sequences.
- Undefined: lock ports absent; pure round-robin as above.

Test Plan:
- req0 LOAD R0 (000, 0x5A) then OUT R0 (100) -> reg_ena one cycle each with correct opcode/data; rsp0_valid at T+3 of OUT with rsp_data=0x5A.
- req0 and req1 valid together, repeatedly, after reset -> grants alternate 0,1,0,1; never two reg_ena in consecutive cycles; ready low while busy.
- CAPTURE_DELAY=3, OUT R1 after LOAD R1 0xC3 -> rsp1_valid at T+5 with rsp_data=0xC3.
- reset asserted in ISSUE cycle of an OUT -> next cycle all outputs 0, no rsp pulse, rr_ptr=0.
- ena=0 held 4 cycles mid-WAIT -> state frozen, reg_ena=0; response arrives exactly 4 cycles late with correct data.
- ARB_LOCK_EN: req1 issues LOAD with lock=1 while req0 valid -> req0_ready stays 0 through req1 MOV (lock=1) and OUT (lock=0); req0 granted in the IDLE cycle after req1's final rsp.
